// File: rtl/apb_wb_bridge.sv
// APB3 completer to pipelined Wishbone initiator bridge with registered outputs,
// stall handling, per-region byte-lane reversal, error propagation and a bus-hang timeout.
module apb_wb_bridge #(
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] SWAP_MASK      = 5'b11000,
  parameter logic [ADDR_WIDTH-1:0] SWAP_BASE      = 5'b11000,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter int                    CNT_WIDTH      = 8,
  localparam int                   NB             = DATA_WIDTH / 8,
  localparam int                   BL             = $clog2(NB)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    apb_PADDR,
  input  logic                     apb_PSEL,
  input  logic                     apb_PENABLE,
  input  logic                     apb_PWRITE,
  input  logic [DATA_WIDTH-1:0]    apb_PWDATA,
  input  logic [NB-1:0]            apb_PSTRB,
  output logic                     apb_PREADY,
  output logic [DATA_WIDTH-1:0]    apb_PRDATA,
  output logic                     apb_PSLVERR,
  output logic [ADDR_WIDTH-BL-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  output logic                     wb_we,
  output logic [NB-1:0]            wb_sel,
  output logic                     wb_cyc,
  output logic                     wb_stb,
  input  logic                     wb_stall,
  input  logic                     wb_ack,
  input  logic                     wb_err,
  output logic                     timeout_pulse
);

  typedef enum logic [1:0] {IDLE, STB, WAIT, RESP} state_e;

  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  function automatic logic [DATA_WIDTH-1:0] byte_rev(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*(NB-1-i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [NB-1:0] bit_rev(input logic [NB-1:0] s);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[NB-1-i] = s[i];
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-BL-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [NB-1:0]           sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    swap_q, swap_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    tmo_q, tmo_d;

  logic swap_hit;
  logic [NB-1:0] launch_sel;
  logic wb_fire;
  logic timed_out;

  assign swap_hit   = ((apb_PADDR & SWAP_MASK) == SWAP_BASE);
  assign launch_sel = apb_PWRITE ? apb_PSTRB : '1;
  // A response during STB only counts once the slave has accepted the request.
  assign wb_fire    = ((state_q == STB) && !wb_stall && (wb_ack || wb_err)) ||
                      ((state_q == WAIT) && (wb_ack || wb_err));
  assign timed_out  = TMO_EN && (cnt_q == TMO_LAST) && !wb_fire;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    swap_d    = swap_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    tmo_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (apb_PSEL && apb_PENABLE) begin
          adr_d   = apb_PADDR[ADDR_WIDTH-1:BL];
          we_d    = apb_PWRITE;
          swap_d  = swap_hit;
          dat_d   = swap_hit ? byte_rev(apb_PWDATA) : apb_PWDATA;
          sel_d   = swap_hit ? bit_rev(launch_sel) : launch_sel;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = STB;
        end
      end
      STB, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (wb_fire) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          pready_d = 1'b1;
          state_d  = RESP;
          if (wb_err) begin
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (we_q) begin
            prdata_d = '0;
          end else begin
            prdata_d = swap_q ? byte_rev(wb_dat_i) : wb_dat_i;
          end
        end else if (timed_out) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          tmo_d     = 1'b1;
          prdata_d  = '0;
          state_d   = RESP;
        end else if ((state_q == STB) && !wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      swap_q    <= 1'b0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      swap_q    <= swap_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign apb_PREADY    = pready_q;
  assign apb_PSLVERR   = pslverr_q;
  assign apb_PRDATA    = prdata_q;
  assign wb_adr        = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel        = sel_q;
  assign wb_we         = we_q;
  assign wb_cyc        = cyc_q;
  assign wb_stb        = stb_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: doc/apb_wb_bridge.md
Name: apb_wb_bridge

Overview:
Parametrised APB3-completer to pipelined-Wishbone-initiator bridge. It replaces the ad hoc glue placed in front of Wishbone peripherals such as the SD card core. Added over the previous glue:
- fully registered Wishbone outputs
- stall handling
- per-region byte-lane reversal, covering data and byte-selects
- Wishbone error propagation
- a bus-hang timeout that converts to PSLVERR

Parameters:
ADDR_WIDTH, 5, APB byte-address width; Wishbone word address is PADDR[ADDR_WIDTH-1:BL], where BL = log2(DATA_WIDTH/8).
DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64.
SWAP_MASK, 5'b11000, address bits compared for the byte-swap region.
SWAP_BASE, 5'b11000, the access is swapped when (PADDR & SWAP_MASK) == SWAP_BASE; SWAP_MASK = 0 swaps every access.
TIMEOUT_CYCLES, 255, cycles allowed from stb assertion to ack/err; 0 disables the timeout.
CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
apb_PADDR  in  ADDR_WIDTH  byte address
apb_PSEL  in  1  select
apb_PENABLE  in  1  access phase
apb_PWRITE  in  1  1 = write
apb_PWDATA  in  DATA_WIDTH  write data
apb_PSTRB  in  DATA_WIDTH/8  write strobes; ignored on reads (all lanes selected)
apb_PREADY  out  1  transfer complete
apb_PRDATA  out  DATA_WIDTH  read data
apb_PSLVERR  out  1  error response
wb_adr  out  ADDR_WIDTH-BL  word address
wb_dat_o  out  DATA_WIDTH  write data
wb_dat_i  in  DATA_WIDTH  read data
wb_we  out  1  write enable
wb_sel  out  DATA_WIDTH/8  byte selects
wb_cyc  out  1  cycle
wb_stb  out  1  strobe
wb_stall  in  1  pipelined stall
wb_ack  in  1  acknowledge
wb_err  in  1  error
timeout_pulse  out  1  one-cycle pulse per timed-out transfer

Behaviour:
- All outputs are registered.
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, cyc=0, stb=0, we=0, sel=0, adr=0, dat_o=0, timeout_pulse=0; state IDLE.
- Reset mid-transfer abandons the transfer. cyc drops on the cycle after reset is sampled, and no response is issued.
- FSM states: IDLE, STB, WAIT, RESP.
- IDLE:
  - When PSEL & PENABLE, latch adr, we, dat_o and sel; clear the counter; next state STB.
  - In STB, cyc=stb=1, first asserted one cycle after the access phase is seen.
  - Setup phase (PSEL & ~PENABLE) is ignored.
- Swap: evaluated on PADDR at launch. When the region matches:
  - dat_o is byte-reversed (lane i goes to lane N-1-i).
  - sel is bit-reversed.
  - Captured read data is byte-reversed before it drives PRDATA.
- STB:
  - stb is held while wb_stall=1; ack/err are ignored while stall=1.
  - When stall=0, the request is accepted and stb drops next cycle.
  - If ack or err arrives in the same accepting cycle, go to RESP; otherwise go to WAIT with cyc still 1.
- WAIT: cyc=1, stb=0. On ack or err, go to RESP.
- ack and err together are treated as err.
- Capture on ack: PRDATA = wb_dat_i (swapped if applicable) for reads; PRDATA = 0 for writes.
- Capture on err: PRDATA = 0, PSLVERR = 1.
- RESP:
  - PREADY=1 for exactly one cycle, PSLVERR valid alongside it, cyc=0.
  - Next state IDLE.
  - PRDATA holds its value until the next capture.
- Latency: the access phase is seen at cycle T; with no stall and ack at T+2, PREADY=1 at T+3.
- Back-to-back transfers: a new setup phase can start in the cycle after RESP. The bridge accepts the access phase at RESP+2 with no lost cycle.
- Timeout:
  - The counter increments every cycle in STB or WAIT.
  - When the counter equals TIMEOUT_CYCLES-1 and no ack/err arrives that cycle: drop cyc/stb, go to RESP with PSLVERR=1 and PRDATA=0, and pulse timeout_pulse for one cycle aligned with PREADY.
  - A late ack/err arriving after cyc has dropped is ignored.
  - With TIMEOUT_CYCLES=0 the bridge waits indefinitely.
- PREADY is never asserted outside RESP. No new Wishbone cycle launches while PREADY=1.

Test Plan:
- Read at PADDR=0x04 (no swap); slave acks 1 cycle after stb with 0x11223344 -> wb_adr=1, wb_sel=4'hF, PRDATA=0x11223344, PREADY at T+3, PSLVERR=0.
- Write at PADDR=0x18 (swap region), PWDATA=0xAABBCCDD, PSTRB=4'b0011 -> wb_dat_o=0xDDCCBBAA, wb_sel=4'b1100, wb_we=1; a read ack of 0x01020304 at the same address -> PRDATA=0x04030201.
- wb_stall held 3 cycles -> stb asserted 4 cycles total; an ack asserted during stall is ignored; PREADY arrives 1 cycle after the real ack.
- Slave returns wb_err on a read -> PSLVERR=1, PRDATA=0, single-cycle PREADY; the next transfer completes normally with PSLVERR=0.
- TIMEOUT_CYCLES=8, slave silent -> cyc drops after 8 cycles of stb/cyc; PREADY=PSLVERR=timeout_pulse=1 for one cycle; a stray ack 2 cycles later causes no PREADY.
- Reset asserted in WAIT -> next cycle cyc=stb=PREADY=0; a subsequent read completes with the correct data.
